// File: rtl/mmio_uart_tx_if.sv
// MEM-stage load/store port into the memory-mapped UART transmitter.
// The CPU side is the master; the UART block is the slave.
interface mmio_uart_tx_if;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output mem_write, mem_read, addr, wdata, input rdata);
    modport slave  (input mem_write, mem_read, addr, wdata, output rdata);
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: byte FIFO fed by stores, LSB-first 8N1 serializer, polled status word.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit (8E1).
module mmio_uart_tx #(
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [31:0] TXDATA_ADDR  = 32'h2000_0000,
    parameter logic [31:0] STATUS_ADDR  = 32'h2000_0004
) (
    input  logic           clk,
    input  logic           rst_n,
    mmio_uart_tx_if.slave  bus,
    output logic           txd
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_ovf;
    logic [31:0]       r_rdata;
    logic [2:0]        r_state;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;
    logic              r_txd;
`ifdef UART_TX_PARITY_EN
    logic              r_par;
`endif

    logic       w_push_req, w_st_rd, w_tx_rd;
    logic       w_full, w_empty, w_busy, w_bit_end;
    logic       w_pop, w_push, w_drop;
    logic [7:0] w_head, w_cnt8;

    assign w_push_req = bus.mem_write && (bus.addr == TXDATA_ADDR);
    assign w_st_rd    = bus.mem_read  && (bus.addr == STATUS_ADDR);
    assign w_tx_rd    = bus.mem_read  && (bus.addr == TXDATA_ADDR);
    assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_busy     = (r_state != S_IDLE) || !w_empty;
    assign w_bit_end  = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
    assign w_head     = r_mem[r_rd_ptr];
    assign w_cnt8     = 8'(r_count);

    // Pops happen from IDLE or at the last stop-bit cycle, so frames chain without a gap.
    assign w_pop  = !w_empty && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign w_push = w_push_req && (!w_full || w_pop);
    assign w_drop = w_push_req && !w_push;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.wdata[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf   <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (w_drop)       r_ovf <= 1'b1;
            else if (w_st_rd) r_ovf <= 1'b0;
            if (w_st_rd)      r_rdata <= {16'h0, w_cnt8, 5'h0, r_ovf, w_full, w_busy};
            else if (w_tx_rd) r_rdata <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_txd     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_par     <= 1'b0;
`endif
        end else if (r_state == S_IDLE) begin
            if (w_pop) begin
                r_shift <= w_head;
                r_baud  <= '0;
                r_state <= S_START;
                r_txd   <= 1'b0;
`ifdef UART_TX_PARITY_EN
                r_par   <= ^w_head;
`endif
            end
        end else if (!w_bit_end) begin
            r_baud <= r_baud + BAUD_W'(1);
        end else begin
            r_baud <= '0;
            case (r_state)
                S_START: begin
                    r_state   <= S_DATA;
                    r_bit_idx <= '0;
                    r_txd     <= r_shift[0];
                end
                S_DATA: begin
                    r_shift <= r_shift >> 1;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        r_state <= S_PARITY;
                        r_txd   <= r_par;
`else
                        r_state <= S_STOP;
                        r_txd   <= 1'b1;
`endif
                    end else begin
                        r_bit_idx <= r_bit_idx + 3'd1;
                        r_txd     <= r_shift[1];
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    r_state <= S_STOP;
                    r_txd   <= 1'b1;
                end
`endif
                S_STOP: begin
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_state <= S_START;
                        r_txd   <= 1'b0;
`ifdef UART_TX_PARITY_EN
                        r_par   <= ^w_head;
`endif
                    end else begin
                        r_state <= S_IDLE;
                        r_txd   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_txd   <= 1'b1;
                end
            endcase
        end
    end

    assign txd       = r_txd;
    assign bus.rdata = r_rdata;
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed scenarios plus random load/store traffic against a
// queue-based frame model; txd and rdata are compared every cycle.
module tb_mmio_uart_tx;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;
    localparam logic [31:0] TXA   = 32'h2000_0000;
    localparam logic [31:0] STA   = 32'h2000_0004;
`ifdef UART_TX_PARITY_EN
    localparam int          FRAME = 11 * CPB;
`else
    localparam int          FRAME = 10 * CPB;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic txd;

    mmio_uart_tx_if bus();

    mmio_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH),
        .TXDATA_ADDR (TXA),
        .STATUS_ADDR (STA)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus),
        .txd  (txd)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Model: queued bytes, plus the remaining per-cycle txd levels of the frame on the wire.
    byte unsigned mq[$];
    bit           fb[$];
    bit           m_ovf;
    logic [31:0]  m_rdata;
    bit           m_txd;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        mq.delete();
        fb.delete();
        m_ovf   = 1'b0;
        m_rdata = '0;
        m_txd   = 1'b1;
    endfunction

    function automatic void m_load(input byte unsigned b);
        for (int i = 0; i < CPB; i++) fb.push_back(1'b0);
        for (int j = 0; j < 8; j++)
            for (int i = 0; i < CPB; i++) fb.push_back(b[j]);
`ifdef UART_TX_PARITY_EN
        for (int i = 0; i < CPB; i++) fb.push_back(^b);
`endif
        for (int i = 0; i < CPB; i++) fb.push_back(1'b1);
    endfunction

    function automatic void m_edge();
        int cnt   = mq.size();
        bit busy  = (fb.size() != 0) || (cnt != 0);
        bit full  = (cnt == DEPTH);
        bit push  = bus.mem_write && (bus.addr == TXA);
        bit rd_st = bus.mem_read  && (bus.addr == STA);
        bit rd_tx = bus.mem_read  && (bus.addr == TXA);
        bit drop  = 1'b0;
        if (fb.size() != 0) fb.delete(0);
        if (fb.size() == 0 && mq.size() != 0) m_load(mq.pop_front());
        if (push) begin
            if (mq.size() < DEPTH) mq.push_back(bus.wdata[7:0]);
            else drop = 1'b1;
        end
        if (rd_st)      m_rdata = {16'h0, 8'(cnt), 5'h0, m_ovf, full, busy};
        else if (rd_tx) m_rdata = '0;
        if (drop)       m_ovf = 1'b1;
        else if (rd_st) m_ovf = 1'b0;
        m_txd = (fb.size() != 0) ? fb[0] : 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        m_edge();
        @(negedge clk);
        chk("txd", 64'(txd), 64'(m_txd));
        chk("rdata", 64'(bus.rdata), 64'(m_rdata));
    endtask

    task automatic bus_idle();
        bus.mem_write = 1'b0;
        bus.mem_read  = 1'b0;
        bus.addr      = '0;
        bus.wdata     = '0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        bus.mem_write = 1'b1;
        bus.addr      = a;
        bus.wdata     = d;
        tick();
        bus_idle();
    endtask

    task automatic load(input logic [31:0] a);
        bus.mem_read = 1'b1;
        bus.addr     = a;
        tick();
        bus_idle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus_idle();
        m_reset();
        repeat (2) @(negedge clk);
        chk("rst_txd", 64'(txd), 64'd1);
        chk("rst_rdata", 64'(bus.rdata), 64'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] w;
        do_reset();

`ifndef UART_TX_PARITY_EN
        // Single 0x55 frame: start, alternating data, stop.
        store(TXA, 32'h0000_0055);
        w = '0;
        for (int i = 0; i < 40; i++) begin
            tick();
            w[i] = txd;
        end
        chk("frame55", w, 64'h0000_00F0_F0F0_F0F0);
        repeat (4) tick();
        load(STA);
        chk("idle_status", 64'(bus.rdata), 64'h0);
`else
        // Parity build: 0x07 has odd popcount, so the parity bit is 1.
        store(TXA, 32'h0000_0007);
        w = '0;
        for (int i = 0; i < 44; i++) begin
            tick();
            w[i] = txd;
        end
        chk("frame07p", w, 64'h0000_0FF0_0000_FFF0);
        repeat (4) tick();
        load(STA);
        chk("idle_status", 64'(bus.rdata), 64'h0);
`endif

        // Fill: five accepted, sixth dropped.
        for (int b = 1; b <= 6; b++) store(TXA, 32'(b));
        load(STA);
        chk("full_ovf", 64'(bus.rdata), 64'h0000_0407);
        load(STA);
        chk("ovf_clr", 64'(bus.rdata), 64'h0000_0403);
        repeat (5 * FRAME + 20) tick();
        load(STA);
        chk("drain", 64'(bus.rdata), 64'h0);

        // Back-to-back frames with no idle gap.
        store(TXA, 32'h0000_00A5);
        store(TXA, 32'h0000_003C);
        chk("b2b_start1", 64'(txd), 64'd0);
        for (int i = 1; i <= 2 * FRAME - 1; i++) begin
            tick();
            if (i == FRAME - 1) chk("b2b_stop1", 64'(txd), 64'd1);
            if (i == FRAME)     chk("b2b_start2", 64'(txd), 64'd0);
        end
        chk("b2b_stop2", 64'(txd), 64'd1);
        load(STA);
        chk("b2b_busy_last", 64'(bus.rdata), 64'h0000_0001);
        load(STA);
        chk("b2b_done", 64'(bus.rdata), 64'h0);

        // Reset mid-DATA with two bytes queued.
        store(TXA, 32'h0000_00FF);
        store(TXA, 32'h0000_0011);
        store(TXA, 32'h0000_0022);
        repeat (8) tick();
        chk("pre_rst_data", 64'(txd), 64'd1);
        #2 rst_n = 1'b0;
        #1 chk("rst_mid_txd", 64'(txd), 64'd1);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3 * FRAME) tick();
        load(STA);
        chk("rst_status", 64'(bus.rdata), 64'h0);

        // Load from TXDATA returns 0; store to STATUS changes nothing.
        store(TXA, 32'h0000_0099);
        load(STA);
        chk("st_one", 64'(bus.rdata), 64'h0000_0101);
        load(TXA);
        chk("ld_txdata", 64'(bus.rdata), 64'h0);
        store(STA, 32'h0000_0077);
        load(STA);
        chk("st_to_status", 64'(bus.rdata), 64'h0000_0001);
        repeat (FRAME + 4) tick();

        // Random traffic; first half fills the FIFO often, second half is sparse.
        for (int c = 0; c < 1600; c++) begin
            int unsigned sel;
            bus_idle();
            if ($urandom_range(0, (c < 800) ? 5 : 40) == 0) bus.mem_write = 1'b1;
            if ($urandom_range(0, 3) == 0) bus.mem_read = 1'b1;
            sel = $urandom_range(0, 3);
            bus.addr  = (sel < 2) ? TXA : (sel == 2) ? STA : 32'h2000_0008;
            bus.wdata = $urandom;
            tick();
        end
        bus_idle();
        repeat (DEPTH * FRAME + 10) tick();
        load(STA);
        chk("rand_drain", 64'(bus.rdata), 64'(m_rdata));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter at the I/O end of the data-memory path. The MEM stage's stores to the UART data address push bytes into a small FIFO here. An FSM serializes each byte onto `txd` as an 8-bit, LSB-first asynchronous frame. A status word at a second address lets software poll for space and for completion before issuing more stores.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per serial bit (100 MHz / 115200). Legal range is ≥ 2.
- `FIFO_DEPTH`, default 16: byte FIFO entries. Must be a power of two, 2 to 128.
- `TXDATA_ADDR`, default 32'h2000_0000: store target for transmit bytes.
- `STATUS_ADDR`, default 32'h2000_0004: load target for the status word.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `mem_write`  in  1: store strobe from the MEM stage.
- `mem_read`  in  1: load strobe from the MEM stage.
- `addr`  in  32: byte address (ALU result).
- `wdata`  in  32: store data; only [7:0] is used.
- `rdata`  out  32: registered status read data.
- `txd`  out  1: serial output; idles high.

## Operation
- Push: the block samples `mem_write && addr==TXDATA_ADDR` on a rising edge. If the FIFO is not full, `wdata[7:0]` is written at the tail. If it is full, the byte is dropped and the sticky `overflow` bit is set.
- Full with a pop in the same cycle: the push is accepted and the count is unchanged.
- Store size is ignored. SB, SH and SW all transmit `wdata[7:0]`.
- Stores to STATUS_ADDR are ignored.
- Status read: on a rising edge with `mem_read && addr==STATUS_ADDR`, `rdata` loads:
  - [0] `busy`: FSM not IDLE, or FIFO non-empty.
  - [1] `full`.
  - [2] `overflow`.
  - [15:8] FIFO count.
  - All other bits 0.
- The same status read clears `overflow`. If a drop occurs in that same cycle, `overflow` stays set.
- A load from TXDATA_ADDR loads `rdata` = 0.
- `rdata` holds its value when no matching read occurs.
- FSM states are IDLE, START, DATA, PARITY, STOP. Each non-IDLE state drives its bit for exactly CLKS_PER_BIT cycles; a baud counter runs 0..CLKS_PER_BIT-1.
  - IDLE, FIFO non-empty: pop the head into the shift register, reset the baud counter, go to START. `txd` = 0.
  - START → DATA. Bit index = 0; `txd` = shift[0].
  - DATA: shift right at each bit end. After bit index 7 ends, go to PARITY (macro defined) or STOP (macro undefined).
  - PARITY → STOP.
  - STOP: `txd` = 1. At the end, go to START with an immediate pop if the FIFO is non-empty (no idle gap), else go to IDLE.
- `txd` is driven from a register. No combinational path from the inputs to `txd`.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo the depth. The count is one bit wider, so full = count==FIFO_DEPTH.

## Timing
- Reset values (async assert, release on the next edge):
  - `txd` = 1, `rdata` = 0.
  - FSM IDLE, FIFO empty, pointers 0, `overflow` = 0, counters 0.
- Reset asserted mid-frame truncates the frame: `txd` goes high immediately and the FIFO contents are discarded.
- Write accepted on edge k into an empty FIFO with the FSM in IDLE:
  - The FSM pops on edge k+1, so `txd` falls after edge k+1.
  - The stop bit ends 10·CLKS_PER_BIT cycles later (11·CLKS_PER_BIT with parity).
- Status read: `rdata` is valid after the edge on which the read is sampled (1-cycle latency). It reflects state before that edge's push or pop.
- Back-to-back frames: the next start bit begins the cycle after the last stop-bit cycle.

## Configuration
- `UART_TX_PARITY_EN` defined: an even-parity bit (XOR of the 8 data bits) is inserted between the last data bit and the stop bit. The frame is 11 bits.
- `UART_TX_PARITY_EN` undefined: no PARITY state is generated and the frame is 10 bits (8N1).
- The status word and all timing are otherwise identical in both builds.

## Test plan
All scenarios use CLKS_PER_BIT=4, FIFO_DEPTH=4.
- Reset, then a single store of 0x55 to 0x2000_0000:
  - `txd` is low for 4 cycles from the edge after the write.
  - Then 1,0,1,0,1,0,1,0 at 4 cycles each, then high for 4 cycles.
  - Status then reads 0x0000_0000.
- Five stores (0x01..0x05) in consecutive cycles while the first frame is sending:
  - All five are accepted; the fifth is accepted because the FSM popped 0x01 earlier.
  - A sixth store 0x06 right away is dropped: status reads `full`=1, `overflow`=1, count=4.
  - A second status read shows `overflow`=0.
- Two queued bytes 0xA5, 0x3C: the second start bit immediately follows the first stop bit. Total 80 cycles, no idle gap.
- Reset pulsed mid-DATA of 0xFF with 2 bytes queued:
  - `txd`=1 within the reset cycle.
  - Status then reads 0 and no further frames are sent.
- Parity build, store 0x07: the bit after data is 1 (odd popcount 3), then the stop bit. The frame spans 44 cycles.
- Load from 0x2000_0000 → `rdata`=0. Store to 0x2000_0004 → no FIFO change.
